// File: rtl/equiv_fuzz_pkg.sv
// Shared constants, types and LFSR helpers for the equivalence-fuzz stimulus generator.
package equiv_fuzz_pkg;

    localparam logic [31:0] LFSR_POLY  = 32'h80200003;
    localparam logic [31:0] B_XOR_MASK = 32'h5A5A5A5A;

    localparam int W0 = 21;
    localparam int W1 = 14;
    localparam int W2 = 21;
    localparam int W3 = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // B is derived from A so one seed drives both; an all-zero B would lock up the LFSR.
    function automatic logic [31:0] seed_b_from_a(input logic [31:0] a);
        logic [31:0] b;
        b = {a[15:0], a[31:16]} ^ B_XOR_MASK;
        return (b == 32'h0) ? 32'h1 : b;
    endfunction

endpackage

// File: rtl/equiv_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable.
module equiv_lfsr32
    import equiv_fuzz_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        en,
    output logic [31:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/equiv_stim_gen.sv
// Seeded pseudo-random stimulus source for the equivalence-fuzz harness.
// Issues num_vecs vectors, drains the compare pipe and records the first mismatching index.
module equiv_stim_gen
    import equiv_fuzz_pkg::*;
#(
    parameter int          CNT_W        = 16,
    parameter int          CHECK_LAT    = 1,
    parameter logic [31:0] DEF_SEED     = 32'hACE11234,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          seed,
    input  logic [CNT_W-1:0]     num_vecs,
    input  logic                 mismatch,
    output logic signed [W0-1:0] wire0,
    output logic [W1-1:0]        wire1,
    output logic [W2-1:0]        wire2,
    output logic signed [W3-1:0] wire3,
    output logic                 vec_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CNT_W-1:0]     fail_idx
);

    state_t               state, state_nxt;
    logic                 accept, active, more, issue;
    logic                 sample, first_fail, stop, chk_valid;
    logic [31:0]          seed_a, seed_b, lfsr_a, lfsr_b;
    logic [CNT_W-1:0]     num_vecs_r, issue_cnt, chk_cnt;
    logic [3:0]           drain_cnt;
    logic [CHECK_LAT-1:0] vpipe;
    logic [CHECK_LAT:0]   vpipe_shift;

    assign accept      = start && (state == IDLE || state == DONE);
    assign active      = (state == RUN) || (state == DRAIN);
    assign seed_a      = (seed == 32'h0) ? DEF_SEED : seed;
    assign seed_b      = seed_b_from_a(seed_a);
    assign more        = (issue_cnt != num_vecs_r);
    assign vpipe_shift = {vpipe, vec_valid};
    assign chk_valid   = vpipe_shift[CHECK_LAT];
    assign sample      = active && chk_valid;
    assign first_fail  = sample && mismatch && !fail;
    assign stop        = STOP_ON_FAIL && first_fail;
    assign issue       = (state == RUN) && more && !stop;
    assign busy        = active;
    assign done        = (state == DONE);

    equiv_lfsr32 u_lfsr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .seed  (seed_a),
        .en    (issue),
        .state (lfsr_a)
    );

    equiv_lfsr32 u_lfsr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .seed  (seed_b),
        .en    (issue),
        .state (lfsr_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN keeps one extra cycle after the last issue so DRAIN starts with vec_valid already low.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (stop) state_nxt = DONE;
                else if (!more) state_nxt = (num_vecs_r == '0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (stop || drain_cnt == 4'(CHECK_LAT - 1)) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wire0      <= '0;
            wire1      <= '0;
            wire2      <= '0;
            wire3      <= '0;
            vec_valid  <= 1'b0;
            fail       <= 1'b0;
            fail_idx   <= '0;
            num_vecs_r <= '0;
            issue_cnt  <= '0;
            chk_cnt    <= '0;
            drain_cnt  <= '0;
            vpipe      <= '0;
        end else if (accept) begin
            num_vecs_r <= num_vecs;
            issue_cnt  <= '0;
            chk_cnt    <= '0;
            fail       <= 1'b0;
            fail_idx   <= '0;
            vec_valid  <= 1'b0;
            drain_cnt  <= '0;
            vpipe      <= '0;
        end else begin
            vec_valid <= issue;
            vpipe     <= vpipe_shift[CHECK_LAT-1:0];
            drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
            if (issue) begin
                wire0     <= lfsr_a[20:0];
                wire1     <= {lfsr_a[31:21], lfsr_b[2:0]};
                wire2     <= lfsr_b[23:3];
                wire3     <= {lfsr_b[31:24], lfsr_a[7:0]};
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            // Results arrive in issue order, so chk_cnt is the index of the vector being judged.
            if (sample) begin
                chk_cnt <= chk_cnt + CNT_W'(1);
                if (first_fail) begin
                    fail     <= 1'b1;
                    fail_idx <= chk_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_equiv_stim_gen.sv
// Directed scoreboard bench for equiv_stim_gen: stop-on-fail instance plus a run-to-completion instance.
module tb_equiv_stim_gen;

    logic               clk, rst, start, mismatch;
    logic [31:0]        seed;
    logic [15:0]        num_vecs;
    logic signed [20:0] w0_a, w0_b;
    logic [13:0]        w1_a, w1_b;
    logic [20:0]        w2_a, w2_b;
    logic signed [15:0] w3_a, w3_b;
    logic               vv_a, vv_b, busy_a, busy_b, done_a, done_b, fail_a, fail_b;
    logic [15:0]        fidx_a, fidx_b;

    bit                 use_nf;
    logic [71:0]        o_vec;
    logic               o_vv, o_busy, o_done, o_fail;
    logic [15:0]        o_fidx;

    int                 checks, errors;
    int                 last_vecs, last_done_cyc;
    bit                 drain_seen;
    logic [71:0]        exp_q[$];
    logic [79:0]        obs_rec[$], saved_rec[$];

    equiv_stim_gen dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vecs(num_vecs),
        .mismatch(mismatch), .wire0(w0_a), .wire1(w1_a), .wire2(w2_a), .wire3(w3_a),
        .vec_valid(vv_a), .busy(busy_a), .done(done_a), .fail(fail_a), .fail_idx(fidx_a)
    );

    equiv_stim_gen #(.STOP_ON_FAIL(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .num_vecs(num_vecs),
        .mismatch(mismatch), .wire0(w0_b), .wire1(w1_b), .wire2(w2_b), .wire3(w3_b),
        .vec_valid(vv_b), .busy(busy_b), .done(done_b), .fail(fail_b), .fail_idx(fidx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (use_nf) begin
            o_vec  = {w0_b, w1_b, w2_b, w3_b};
            o_vv   = vv_b;
            o_busy = busy_b;
            o_done = done_b;
            o_fail = fail_b;
            o_fidx = fidx_b;
        end else begin
            o_vec  = {w0_a, w1_a, w2_a, w3_a};
            o_vv   = vv_a;
            o_busy = busy_a;
            o_done = done_a;
            o_fail = fail_a;
            o_fidx = fidx_a;
        end
    end

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h80200003;
        return r;
    endfunction

    function automatic logic [71:0] model_vec(input logic [31:0] a, input logic [31:0] b);
        return {a[20:0], a[31:21], b[2:0], b[23:3], b[31:24], a[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, "_fields"}, 80'(o_vec), 80'd0);
        check_output({tag, "_vec_valid"}, 80'(o_vv), 80'd0);
        check_output({tag, "_busy"}, 80'(o_busy), 80'd0);
        check_output({tag, "_done"}, 80'(o_done), 80'd0);
        check_output({tag, "_fail"}, 80'(o_fail), 80'd0);
        check_output({tag, "_fail_idx"}, 80'(o_fidx), 80'd0);
    endtask

    // Asynchronous reset, checked between clock edges.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        check_zero(tag);
        tick();
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input string name, input logic [31:0] s, input logic [15:0] n,
                                  input logic [31:0] mm_mask, input int exp_vecs,
                                  input bit exp_fail, input int exp_idx,
                                  input int busy_start_at, input int abort_at);
        logic [31:0] a, b;
        int          cyc, vecs;
        bit          pending, aborted;
        exp_q.delete();
        obs_rec.delete();
        a = (s == 32'h0) ? 32'hACE11234 : s;
        b = {a[15:0], a[31:16]} ^ 32'h5A5A5A5A;
        if (b == 32'h0) b = 32'h1;
        for (int k = 0; k < int'(n); k++) begin
            exp_q.push_back(model_vec(a, b));
            a = model_step(a);
            b = model_step(b);
        end
        seed     = s;
        num_vecs = n;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check_output({name, "_busy_after_start"}, 80'(o_busy), 80'd1);
        cyc = 0; vecs = 0; pending = 1'b0; aborted = 1'b0;
        last_done_cyc = -1; drain_seen = 1'b0;
        while (cyc < int'(n) + 20) begin
            tick();
            cyc++;
            start = 1'b0;
            if (cyc == abort_at) begin
                pulse_reset({name, "_abort"});
                aborted = 1'b1;
                break;
            end
            mismatch = pending;
            pending  = o_vv && (vecs < 32) && mm_mask[vecs];
            if (o_vv) begin
                check_output({name, "_sb_nonempty"}, 80'(exp_q.size() != 0), 80'd1);
                if (exp_q.size() != 0) check_output({name, "_vec"}, 80'(o_vec), 80'(exp_q.pop_front()));
                obs_rec.push_back({8'(cyc), o_vec});
                vecs++;
            end else if (o_busy) begin
                drain_seen = 1'b1;
            end
            if (cyc == busy_start_at) begin
                start    = 1'b1;
                seed     = 32'h0BADF00D;
                num_vecs = 16'd2;
            end
            if (o_done) begin
                last_done_cyc = cyc;
                break;
            end
        end
        mismatch  = 1'b0;
        last_vecs = vecs;
        if (!aborted) begin
            check_output({name, "_done"}, 80'(o_done), 80'd1);
            check_output({name, "_vec_count"}, 80'(vecs), 80'(exp_vecs));
            check_output({name, "_fail"}, 80'(o_fail), 80'(exp_fail));
            if (exp_fail) check_output({name, "_fail_idx"}, 80'(o_fidx), 80'(exp_idx));
        end
    endtask

    initial begin
        checks = 0; errors = 0; use_nf = 1'b0;
        rst = 1'b1; start = 1'b0; seed = '0; num_vecs = '0; mismatch = 1'b0;
        tick();
        pulse_reset("reset_init");

        apply_stimulus("t1", 32'h1, 16'd4, 32'h0, 4, 1'b0, 0, -1, -1);
        check_output("t1_vec0_w0", 80'(obs_rec[0][71:51]), 80'h000001);
        check_output("t1_vec0_w1", 80'(obs_rec[0][50:37]), 80'h0002);
        check_output("t1_vec0_w2", 80'(obs_rec[0][36:16]), 80'h0B6B4B);
        check_output("t1_vec0_w3", 80'(obs_rec[0][15:0]), 80'h5A01);
        check_output("t1_vec1_w0", 80'(obs_rec[1][71:51]), 80'h000003);
        check_output("t1_drain_seen", 80'(drain_seen), 80'd1);

        apply_stimulus("t2_zero", 32'h0, 16'd6, 32'h0, 6, 1'b0, 0, -1, -1);
        saved_rec = obs_rec;
        apply_stimulus("t2_def", 32'hACE11234, 16'd6, 32'h0, 6, 1'b0, 0, -1, -1);
        check_output("t2_len", 80'(obs_rec.size()), 80'(saved_rec.size()));
        for (int i = 0; i < saved_rec.size(); i++) check_output("t2_same", obs_rec[i], saved_rec[i]);

        apply_stimulus("t3", 32'h12345678, 16'd5, 32'h4, 4, 1'b1, 2, -1, -1);
        check_output("t3_done_cycle", 80'(last_done_cyc), 80'd5);

        apply_stimulus("t5_zero", 32'h7, 16'd0, 32'h0, 0, 1'b0, 0, -1, -1);
        check_output("t5_done_cycle", 80'(last_done_cyc), 80'd1);
        apply_stimulus("t5_busy_start", 32'h9, 16'd6, 32'h0, 6, 1'b0, 0, 2, -1);

        pulse_reset("t4_reset");
        use_nf = 1'b1;
        apply_stimulus("t4", 32'h00C0FFEE, 16'd10, 32'hA0, 10, 1'b1, 5, -1, -1);
        use_nf = 1'b0;

        apply_stimulus("t6_abort", 32'h5, 16'd8, 32'h0, 0, 1'b0, 0, -1, 3);
        apply_stimulus("t6_restart", 32'h5, 16'd8, 32'h0, 8, 1'b0, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
